glb_gin_streamer: RTL and testbench

Parametrised read-side sequencer between one single-port global buffer (GLB) and one global input network (GIN) of the ML accelerator. On a start command it reads a contiguous GLB region, tags each word with a row/column destination, and delivers `{row_tag, col_tag, data}` packets to the GIN under a valid/ready handshake at up to one packet per cycle. It replaces hand-driven GLB/GIN control and is instantiated once per data type (ifmap, filter, psum).

---
 rtl/accel_pkg.sv | 20 ++
 rtl/stream_skid_fifo.sv | 56 +++++
 rtl/glb_gin_streamer.sv | 147 ++++++++++++++
 tb/tb_glb_gin_streamer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared types for the accelerator GLB/GIN streaming blocks.
// Packet width derivation, tag modes and streamer FSM encoding.
package accel_pkg;

   function automatic int pkt_len(input int bw, input int tl);
      return 2 * tl + bw;
   endfunction

   typedef enum logic {
      TAG_FIXED  = 1'b0,
      TAG_RASTER = 1'b1
   } tag_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry word FIFO holding GLB read data ahead of the GIN.
// Entry 0 is always the head, so the output needs no read pointer.
module stream_skid_fifo #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic [W-1:0] dout_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] e0_q, e1_q;
   logic [1:0]   cnt_q;
   logic         pop_ok, push_ok;

   assign pop_ok  = pop_i && (cnt_q != 2'd0);
   assign push_ok = push_i && ((cnt_q != 2'd2) || pop_ok);
   assign dout_o  = e0_q;
   assign count_o = cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= 2'd0;
      end else if (flush_i) begin
         cnt_q <= 2'd0;
      end else begin
         unique case ({push_ok, pop_ok})
            2'b11: begin
               if (cnt_q == 2'd2) begin
                  e0_q <= e1_q;
                  e1_q <= din_i;
               end else begin
                  e0_q <= din_i;
               end
            end
            2'b10: begin
               if (cnt_q == 2'd0) e0_q <= din_i;
               else               e1_q <= din_i;
               cnt_q <= cnt_q + 2'd1;
            end
            2'b01: begin
               e0_q  <= e1_q;
               cnt_q <= cnt_q - 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/glb_gin_streamer.sv
// Reads a contiguous GLB region and streams tagged packets to one GIN.
// One instance per data type (ifmap, filter, psum).
module glb_gin_streamer
   import accel_pkg::*;
#(
   parameter int BITWIDTH        = 16,
   parameter int GLB_ADDR_LENGTH = 8,
   parameter int TAG_LENGTH      = 4,
   parameter int PE_Y_SIZE       = 4,
   parameter int PE_X_SIZE       = 4,
   parameter int PACKET_LENGTH   = pkt_len(BITWIDTH, TAG_LENGTH)
) (
   input  logic                       clk,
   input  logic                       rstb,
   input  logic                       start,
   input  logic [GLB_ADDR_LENGTH-1:0] base_addr,
   input  logic [GLB_ADDR_LENGTH:0]   length,
   input  logic [TAG_LENGTH-1:0]      row_tag_init,
   input  logic [TAG_LENGTH-1:0]      col_tag_init,
   input  logic                       tag_mode,
   input  logic                       flush,
   output logic [GLB_ADDR_LENGTH-1:0] glb_addr,
   output logic                       glb_cs,
   output logic                       glb_oe,
   output logic                       glb_we,
   input  logic [BITWIDTH-1:0]        glb_rdata,
   output logic [PACKET_LENGTH-1:0]   data_packet,
   output logic                       gin_enable,
   input  logic                       gin_ready,
   output logic                       busy,
   output logic                       done
);

   localparam logic [TAG_LENGTH-1:0] XLAST = TAG_LENGTH'(PE_X_SIZE - 1);
   localparam logic [TAG_LENGTH-1:0] YLAST = TAG_LENGTH'(PE_Y_SIZE - 1);

   state_e                     state_q;
   tag_mode_e                  mode_q;
   logic [GLB_ADDR_LENGTH-1:0] addr_q;
   logic [GLB_ADDR_LENGTH:0]   rd_left_q;
   logic [GLB_ADDR_LENGTH:0]   pk_left_q;
   logic [TAG_LENGTH-1:0]      row_q, col_q;
   logic [TAG_LENGTH-1:0]      row_d, col_d;
   logic                       pend_q;
   logic                       done_q;

   logic [1:0]                 occ;
   logic [BITWIDTH-1:0]        head;
   logic [2:0]                 load;
   logic                       pop;
   logic                       issue;

   stream_skid_fifo #(
      .W(BITWIDTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rstb),
      .push_i  (pend_q),
      .din_i   (glb_rdata),
      .pop_i   (pop),
      .flush_i (flush),
      .dout_o  (head),
      .count_o (occ)
   );

   assign gin_enable = (occ != 2'd0);
   assign pop        = gin_enable && gin_ready;

   // Counting this cycle's pop keeps the stream at one word per cycle.
   assign load  = 3'(occ) + 3'(pend_q) - 3'(pop);
   assign issue = (state_q == ST_RUN) && !flush && (load < 3'd2);

   assign glb_cs   = issue;
   assign glb_oe   = issue;
   assign glb_we   = 1'b0;
   assign glb_addr = addr_q;

   assign data_packet = gin_enable ? {row_q, col_q, head} : '0;
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (mode_q == TAG_RASTER) begin
         if (col_q >= XLAST) begin
            col_d = '0;
            row_d = (row_q >= YLAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q   <= ST_IDLE;
         mode_q    <= TAG_FIXED;
         addr_q    <= '0;
         rd_left_q <= '0;
         pk_left_q <= '0;
         row_q     <= '0;
         col_q     <= '0;
         pend_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         pend_q <= issue;
         if (flush) begin
            state_q <= ST_IDLE;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     addr_q    <= base_addr;
                     rd_left_q <= length;
                     pk_left_q <= length;
                     row_q     <= row_tag_init;
                     col_q     <= col_tag_init;
                     mode_q    <= tag_mode_e'(tag_mode);
                     if (length == '0) done_q  <= 1'b1;
                     else              state_q <= ST_RUN;
                  end
               end
               ST_RUN, ST_DRAIN: begin
                  if (issue) begin
                     addr_q    <= addr_q + 1'b1;
                     rd_left_q <= rd_left_q - 1'b1;
                     if (rd_left_q == 1) state_q <= ST_DRAIN;
                  end
                  if (pop) begin
                     row_q     <= row_d;
                     col_q     <= col_d;
                     pk_left_q <= pk_left_q - 1'b1;
                     if (pk_left_q == 1) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                     end
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_glb_gin_streamer.sv
// Randomized bench for glb_gin_streamer against a packet-list model.
// A GLB array answers reads; a monitor scores every GIN transfer.
module tb_glb_gin_streamer;

   localparam int BW = 16;
   localparam int AW = 8;
   localparam int TL = 4;
   localparam int PY = 4;
   localparam int PX = 4;
   localparam int PL = 2 * TL + BW;

   logic          clk = 1'b0;
   logic          rstb = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic [TL-1:0] row_tag_init = '0;
   logic [TL-1:0] col_tag_init = '0;
   logic          tag_mode = 1'b0;
   logic          flush = 1'b0;
   logic [AW-1:0] glb_addr;
   logic          glb_cs, glb_oe, glb_we;
   logic [BW-1:0] glb_rdata = '0;
   logic [PL-1:0] data_packet;
   logic          gin_enable;
   logic          gin_ready = 1'b0;
   logic          busy, done;

   glb_gin_streamer #(
      .BITWIDTH(BW), .GLB_ADDR_LENGTH(AW), .TAG_LENGTH(TL),
      .PE_Y_SIZE(PY), .PE_X_SIZE(PX), .PACKET_LENGTH(PL)
   ) dut (
      .clk(clk), .rstb(rstb), .start(start), .base_addr(base_addr),
      .length(length), .row_tag_init(row_tag_init),
      .col_tag_init(col_tag_init), .tag_mode(tag_mode), .flush(flush),
      .glb_addr(glb_addr), .glb_cs(glb_cs), .glb_oe(glb_oe),
      .glb_we(glb_we), .glb_rdata(glb_rdata), .data_packet(data_packet),
      .gin_enable(gin_enable), .gin_ready(gin_ready), .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   logic [BW-1:0] mem [256];
   int cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (glb_cs && glb_oe) glb_rdata <= mem[glb_addr];
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [PL-1:0] exp_q [$];
   logic [AW-1:0] m_base = '0;
   int nrd = 0, nacc = 0, ndone = 0;
   int first_cyc = -1, done_cyc = -1, bp = 0, s_cyc = 0;
   bit mon_en = 0;
   bit prev_stall = 0;
   logic [PL-1:0] prev_pkt = '0;

   initial forever begin
      @(negedge clk);
      case (bp)
         0:       gin_ready = 1'b1;
         1:       gin_ready = (cyc % 3 == 0);
         2:       gin_ready = 1'($urandom_range(0, 1));
         default: gin_ready = 1'b0;
      endcase
   end

   always begin
      @(negedge clk);
      #1;
      if (mon_en && rstb) begin
         if (prev_stall)
            check("hold", {gin_enable, data_packet}, {1'b1, prev_pkt});
         if (glb_cs) begin
            check("glb_rd", {glb_oe, glb_we, glb_addr},
                  {1'b1, 1'b0, m_base + AW'(nrd)});
            nrd++;
         end
         if (gin_enable && gin_ready) begin
            if (first_cyc < 0) first_cyc = cyc;
            nacc++;
            check("pkt_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("pkt", data_packet, exp_q.pop_front());
         end
         if (glb_cs) check("outstanding", (nrd - nacc) <= 2, 1);
         prev_stall = gin_enable && !gin_ready;
         prev_pkt   = data_packet;
         if (done) begin
            ndone++;
            done_cyc = cyc;
         end
      end
   end

   task automatic start_cmd(input logic [AW-1:0] b, input int len,
                            input int r, input int c, input logic m,
                            input int bpm, input bit poke);
      int idx;
      logic [AW-1:0] a;
      exp_q.delete();
      for (int k = 0; k < len; k++) begin
         a = b + AW'(k);
         idx = c + k;
         if (m)
            exp_q.push_back({TL'((r + idx / PX) % PY), TL'(idx % PX), mem[a]});
         else
            exp_q.push_back({TL'(r), TL'(c), mem[a]});
      end
      m_base = b; nrd = 0; nacc = 0; ndone = 0;
      first_cyc = -1; done_cyc = -1; prev_stall = 0;
      bp = bpm; mon_en = 1;
      @(negedge clk);
      s_cyc = cyc;
      base_addr = b; length = (AW+1)'(len);
      row_tag_init = TL'(r); col_tag_init = TL'(c);
      tag_mode = m; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (poke) begin
         start = 1'b1; base_addr = ~b; length = 9'd3; tag_mode = ~m;
      end
      #2;
      if (len > 0) check("busy_after_start", busy, 1);
      if (poke) begin
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic run(input logic [AW-1:0] b, input int len,
                      input int r, input int c, input logic m,
                      input int bpm, input bit poke);
      start_cmd(b, len, r, c, m, bpm, poke);
      for (int i = 0; i < 600 && ndone == 0; i++) begin
         @(negedge clk);
         #2;
      end
      check("done_seen", ndone, 1);
      check("busy_at_done", busy, 0);
      check("left_over", exp_q.size(), 0);
      check("reads", nrd, len);
      if (bpm == 0) begin
         check("t_done", done_cyc - s_cyc, (len == 0) ? 1 : len + 3);
         if (len > 0) check("t_first", first_cyc - s_cyc, 3);
      end
      @(negedge clk);
      #2;
      check("done_pulse", {done, 32'(ndone)}, {1'b0, 32'd1});
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = BW'($urandom);
      for (int i = 0; i < 4; i++) mem[8'h10 + i] = BW'(16'hA0 + i);
      #13;
      check("reset_vals", {glb_addr, glb_cs, glb_oe, glb_we, data_packet,
                           gin_enable, busy, done}, 0);
      @(negedge clk);
      rstb = 1'b1;

      run(8'h10, 4, 2, 3, 1'b0, 0, 0);
      run(8'($urandom), 6, 0, 2, 1'b1, 0, 0);
      run(8'h40, 5, 1, 1, 1'b1, 1, 1);
      run(8'hFE, 3, 3, 0, 1'b0, 0, 0);
      run(8'h33, 0, 0, 0, 1'b0, 0, 0);

      start_cmd(8'h80, 8, 0, 0, 1'b1, 0, 0);
      for (int i = 0; i < 40 && nacc < 2; i++) begin
         @(negedge clk);
         #2;
      end
      @(negedge clk);
      flush = 1'b1;
      bp = 3;
      @(negedge clk);
      flush = 1'b0;
      #2;
      check("flush_idle", {gin_enable, busy}, 2'b00);
      for (int i = 0; i < 6; i++) @(negedge clk);
      check("flush_no_done", ndone, 0);
      run(8'h81, 4, 1, 3, 1'b1, 0, 0);

      for (int t = 0; t < 10; t++) begin
         int len;
         len = $urandom_range(0, 12);
         run(8'($urandom), len, $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), $urandom_range(0, 2),
             (len > 0) && ($urandom_range(0, 1) == 1));
      end
      run(8'($urandom), 256, 2, 1, 1'b1, 0, 0);

      start_cmd(8'h20, 10, 0, 0, 1'b0, 2, 0);
      for (int i = 0; i < 4; i++) @(negedge clk);
      mon_en = 0;
      #3 rstb = 1'b0;
      #1;
      check("async_reset", {glb_addr, glb_cs, glb_oe, glb_we, data_packet,
                            gin_enable, busy, done}, 0);
      @(negedge clk);
      rstb = 1'b1;
      run(8'h20, 5, 3, 2, 1'b1, 2, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
